ex_alu_unit: RTL and testbench

Execute-stage ALU that consumes the 5-bit ALUCtrl code and the Sign flag from the ALU control unit, plus the two operands from the ID/EX register. Single-cycle ops register their result in one cycle. MUL runs as an iterative 32-cycle shift-add and asserts busy so the hazard unit stalls the front of the pipeline. The result, zero and overflow outputs are registered and feed the EX/MEM boundary.

---
 rtl/ex_alu_unit.sv | 145 ++++++++++++++
 tb/tb_ex_alu_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_alu_unit.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops plus an
// iterative shift-add multiplier that holds busy while it runs.
module ex_alu_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [4:0]       ALUCtrl,
    input  logic             Sign,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             flush,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    localparam logic [4:0] OP_AND = 5'b00000;
    localparam logic [4:0] OP_OR  = 5'b00001;
    localparam logic [4:0] OP_ADD = 5'b00010;
    localparam logic [4:0] OP_SUB = 5'b00110;
    localparam logic [4:0] OP_SLT = 5'b00111;
    localparam logic [4:0] OP_NOR = 5'b01100;
    localparam logic [4:0] OP_XOR = 5'b01101;
    localparam logic [4:0] OP_SLL = 5'b10000;
    localparam logic [4:0] OP_SRL = 5'b11000;
    localparam logic [4:0] OP_SRA = 5'b11001;
    localparam logic [4:0] OP_MUL = 5'b11010;

    localparam int CW = $clog2(MUL_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYCLES - 1);

    typedef enum logic {
        IDLE,
        MUL_BUSY
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] mcand, mplier, acc, acc_nx;
    logic [WIDTH-1:0] alu_res, sum, diff;
    logic [CW-1:0]    cnt;
    logic [4:0]       shamt;
    logic             alu_ovf, slt, is_mul, mul_done;

    assign busy     = (state == MUL_BUSY);
    assign zero     = (result == '0);
    assign is_mul   = (ALUCtrl == OP_MUL);
    assign mul_done = busy && (cnt == CNT_LAST);
    assign acc_nx   = mplier[0] ? acc + mcand : acc;

    assign sum   = in_a + in_b;
    assign diff  = in_a - in_b;
    assign shamt = in_a[4:0];
    assign slt   = Sign ? ($signed(in_a) < $signed(in_b)) : (in_a < in_b);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (ALUCtrl)
            OP_AND: alu_res = in_a & in_b;
            OP_OR:  alu_res = in_a | in_b;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = Sign && (in_a[WIDTH-1] == in_b[WIDTH-1])
                               && (sum[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = Sign && (in_a[WIDTH-1] != in_b[WIDTH-1])
                               && (diff[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt};
            OP_NOR: alu_res = ~(in_a | in_b);
            OP_XOR: alu_res = in_a ^ in_b;
            OP_SLL: alu_res = in_b << shamt;
            OP_SRL: alu_res = in_b >> shamt;
            OP_SRA: alu_res = $unsigned($signed(in_b) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:     if (in_valid && is_mul) state_nx = MUL_BUSY;
                MUL_BUSY: if (mul_done) state_nx = IDLE;
                default:  state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Flush kills without touching result/overflow so EX/MEM sees stale data only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            out_valid <= 1'b0;
            if (flush) begin
                cnt <= '0;
            end else if (state == IDLE) begin
                if (in_valid && is_mul) begin
                    mcand  <= in_a;
                    mplier <= in_b;
                    acc    <= '0;
                    cnt    <= '0;
                end else if (in_valid) begin
                    result    <= alu_res;
                    overflow  <= alu_ovf;
                    out_valid <= 1'b1;
                end
            end else begin
                acc    <= acc_nx;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (mul_done) begin
                    result    <= acc_nx;
                    overflow  <= 1'b0;
                    out_valid <= 1'b1;
                    cnt       <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_alu_unit.sv
// Randomised self-checking bench for ex_alu_unit against an
// arithmetic reference model.
module tb_ex_alu_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [4:0]  ALUCtrl;
    logic        Sign;
    logic [31:0] in_a, in_b;
    logic        flush;
    logic        busy, out_valid, zero, overflow;
    logic [31:0] result;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] last_res;
    logic        last_ovf;

    always #5 clk = ~clk;

    ex_alu_unit #(.WIDTH(32), .MUL_CYCLES(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .ALUCtrl(ALUCtrl), .Sign(Sign), .in_a(in_a), .in_b(in_b),
        .flush(flush), .busy(busy), .out_valid(out_valid),
        .result(result), .zero(zero), .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [4:0] op, input logic sg,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ov);
        longint s;
        logic [63:0] p;
        r  = 32'd0;
        ov = 1'b0;
        case (op)
            5'b00000: r = a & b;
            5'b00001: r = a | b;
            5'b00010: begin
                r = a + b;
                s = longint'($signed(a)) + longint'($signed(b));
                ov = sg && (s > 64'sd2147483647 || s < -64'sd2147483648);
            end
            5'b00110: begin
                r = a - b;
                s = longint'($signed(a)) - longint'($signed(b));
                ov = sg && (s > 64'sd2147483647 || s < -64'sd2147483648);
            end
            5'b00111: r = (sg ? ($signed(a) < $signed(b)) : (a < b)) ? 1 : 0;
            5'b01100: r = ~(a | b);
            5'b01101: r = a ^ b;
            5'b10000: r = b << a[4:0];
            5'b11000: r = b >> a[4:0];
            5'b11001: r = $unsigned($signed(b) >>> a[4:0]);
            5'b11010: begin
                p = {32'd0, a} * {32'd0, b};
                r = p[31:0];
            end
            default: r = 32'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [4:0] op, input logic sg,
                         input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        logic        eo;
        model(op, sg, a, b, er, eo);
        in_valid = 1'b1; ALUCtrl = op; Sign = sg; in_a = a; in_b = b;
        tick();
        in_valid = 1'b0;
        chk("op_valid", {31'd0, out_valid}, 32'd1);
        chk($sformatf("op%0h_res", op), result, er);
        chk($sformatf("op%0h_ovf", op), {31'd0, overflow}, {31'd0, eo});
        chk("op_zero", {31'd0, zero}, {31'd0, er == 32'd0});
        last_res = er;
        last_ovf = eo;
    endtask

    task automatic do_mul(input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input int flush_at,
                          input logic hold_add);
        logic [31:0] er;
        logic        eo;
        int          n;
        logic        flushed;
        logic        early;
        model(5'b11010, sg, a, b, er, eo);
        in_valid = 1'b1; ALUCtrl = 5'b11010; Sign = sg; in_a = a; in_b = b;
        tick();
        chk("mul_accept_busy", {31'd0, busy}, 32'd1);
        chk("mul_accept_ov", {31'd0, out_valid}, 32'd0);
        in_valid = hold_add;
        ALUCtrl = 5'b00010; in_a = 32'd1; in_b = 32'd1;
        n = 0; flushed = 1'b0; early = 1'b0;
        while (busy && n < 40 && !flushed) begin
            n++;
            if (out_valid) early = 1'b1;
            if (n == flush_at) flush = 1'b1;
            tick();
            if (flush) begin
                flush = 1'b0;
                flushed = 1'b1;
            end
        end
        in_valid = 1'b0;
        chk("mul_no_early_ov", {31'd0, early}, 32'd0);
        if (flushed) begin
            chk("flush_busy", {31'd0, busy}, 32'd0);
            chk("flush_ov", {31'd0, out_valid}, 32'd0);
            chk("flush_res_hold", result, last_res);
            chk("flush_ovf_hold", {31'd0, overflow}, {31'd0, last_ovf});
        end else begin
            chk("mul_busy_cycles", n, 32'd32);
            chk("mul_ov", {31'd0, out_valid}, 32'd1);
            chk("mul_res", result, er);
            chk("mul_ovf", {31'd0, overflow}, 32'd0);
            last_res = er;
            last_ovf = 1'b0;
            tick();
            chk("mul_ov_pulse", {31'd0, out_valid}, 32'd0);
        end
    endtask

    function automatic logic [31:0] rnd();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    logic [4:0] ops [12] = '{5'b00000, 5'b00001, 5'b00010, 5'b00110,
                             5'b00111, 5'b01100, 5'b01101, 5'b10000,
                             5'b11000, 5'b11001, 5'b11010, 5'b00011};

    initial begin
        logic spurious;
        logic [4:0] op;
        rst_n = 1'b0; in_valid = 1'b0; ALUCtrl = '0; Sign = 1'b0;
        in_a = '0; in_b = '0; flush = 1'b0;
        last_res = 32'd0; last_ovf = 1'b0;
        #1;
        chk("rst_res", result, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ov", {31'd0, out_valid}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        do_op(5'b00010, 1'b1, 32'h7FFF_FFFF, 32'd1);
        chk("add_ovf_dir", {31'd0, overflow}, 32'd1);
        do_op(5'b00010, 1'b0, 32'h7FFF_FFFF, 32'd1);
        do_op(5'b00111, 1'b1, 32'hFFFF_FFFF, 32'd1);
        do_op(5'b00111, 1'b0, 32'hFFFF_FFFF, 32'd1);
        do_op(5'b11001, 1'b0, 32'd4, 32'h8000_0000);
        chk("sra_dir", result, 32'hF800_0000);
        do_op(5'b11000, 1'b0, 32'd4, 32'h8000_0000);
        chk("srl_dir", result, 32'h0800_0000);
        tick();
        chk("idle_ov", {31'd0, out_valid}, 32'd0);
        chk("idle_hold", result, last_res);

        do_mul(1'b1, 32'd12345, 32'hFFFF_FFFD, 0, 1'b1);
        chk("mul_dir", result, 32'hFFFF_6F55);
        do_mul(1'b0, 32'd7, 32'd9, 10, 1'b0);
        do_op(5'b00010, 1'b0, 32'd2, 32'd3);
        chk("add_after_flush", result, 32'd5);

        in_valid = 1'b1; ALUCtrl = 5'b11010; in_a = 32'd3; in_b = 32'd5;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_zero", {31'd0, zero}, 32'd1);
        chk("midrst_res", result, 32'd0);
        tick();
        rst_n = 1'b1;
        last_res = 32'd0; last_ovf = 1'b0;
        spurious = 1'b0;
        repeat (40) begin
            tick();
            if (out_valid || busy) spurious = 1'b1;
        end
        chk("postrst_quiet", {31'd0, spurious}, 32'd0);

        for (int i = 0; i < 300; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31))
                                             : ops[$urandom_range(0, 11)];
            if (op == 5'b11010) begin
                do_mul(1'($urandom), rnd(), rnd(),
                       ($urandom_range(0, 2) == 0) ? $urandom_range(1, 32) : 0,
                       1'($urandom));
            end else if ($urandom_range(0, 19) == 0) begin
                in_valid = 1'b1; ALUCtrl = op; in_a = rnd(); in_b = rnd();
                flush = 1'b1;
                tick();
                flush = 1'b0; in_valid = 1'b0;
                chk("flush_op_ov", {31'd0, out_valid}, 32'd0);
                chk("flush_op_hold", result, last_res);
            end else begin
                do_op(op, 1'($urandom), rnd(), rnd());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
